// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, write/read FSM state encodings and
// the helper that turns the data width into the address byte-offset shift.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    function automatic int byteShift(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_wr_ctrl.sv
// AXI4-Lite write-side controller: captures AW and W independently, then issues
// a single-cycle commit strobe with the decoded register index and error flag.
module axi4_lite_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int IDX_W     = $clog2(NUM_REGS),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic                  o_commit,
    output logic                  o_err,
    output logic [IDX_W-1:0]      o_idx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [STRB_W-1:0]     o_strb
);

    localparam int SHIFT = byteShift(DATA_WIDTH);

    wr_state_e             r_state;
    wr_state_e             w_nextState;
    logic                  r_awCaptured;
    logic                  r_wCaptured;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [STRB_W-1:0]     r_strb;
    resp_e                 r_bresp;
    logic                  w_awHs;
    logic                  w_wHs;
    logic [ADDR_WIDTH-1:0] w_wordAddr;

    assign w_awHs     = i_awvalid && o_awready;
    assign w_wHs      = i_wvalid && o_wready;
    assign w_wordAddr = r_addr >> SHIFT;

    assign o_err   = (w_wordAddr >= ADDR_WIDTH'(NUM_REGS));
    assign o_idx   = w_wordAddr[IDX_W-1:0];
    assign o_data  = r_data;
    assign o_strb  = r_strb;
    assign o_bresp = r_bresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Commit as soon as both halves are held, whether they arrived together or apart.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            W_IDLE: begin
                if ((r_awCaptured || w_awHs) && (r_wCaptured || w_wHs)) begin
                    w_nextState = W_COMMIT;
                end
            end
            W_COMMIT: w_nextState = W_RESP;
            W_RESP: begin
                if (i_bready) begin
                    w_nextState = W_IDLE;
                end
            end
            default: w_nextState = W_IDLE;
        endcase
    end

    always_comb begin
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        o_commit  = 1'b0;
        case (r_state)
            W_IDLE: begin
                o_awready = !r_awCaptured && !rst;
                o_wready  = !r_wCaptured && !rst;
            end
            W_COMMIT: o_commit = 1'b1;
            W_RESP:   o_bvalid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awCaptured <= 1'b0;
            r_wCaptured  <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_strb       <= '0;
            r_bresp      <= OKAY;
        end else begin
            if (w_awHs) begin
                r_awCaptured <= 1'b1;
                r_addr       <= i_awaddr;
            end
            if (w_wHs) begin
                r_wCaptured <= 1'b1;
                r_data      <= i_wdata;
                r_strb      <= i_wstrb;
            end
            if (r_state == W_COMMIT) begin
                r_awCaptured <= 1'b0;
                r_wCaptured  <= 1'b0;
                r_bresp      <= o_err ? SLVERR : OKAY;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with independent read and write paths.
// Optional per-register write pulse output enabled by AXI4_LITE_REGBANK_WR_PULSE_EN.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]            wr_pulse_o
`endif
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = byteShift(DATA_WIDTH);

    logic                  w_commit;
    logic                  w_wrErr;
    logic [IDX_W-1:0]      w_wrIdx;
    logic [DATA_WIDTH-1:0] w_wrData;
    logic [STRB_W-1:0]     w_wrStrb;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    rd_state_e             r_rdState;
    rd_state_e             w_rdNext;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_e                 r_rresp;
    logic [ADDR_WIDTH-1:0] w_rdWordAddr;
    logic                  w_rdErr;
    logic [IDX_W-1:0]      w_rdIdx;
    logic                  w_arHs;

    axi4_lite_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wrCtrl (
        .clk       (clk),
        .rst       (rst),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .o_commit  (w_commit),
        .o_err     (w_wrErr),
        .o_idx     (w_wrIdx),
        .o_data    (w_wrData),
        .o_strb    (w_wrStrb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !w_wrErr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wrStrb[b]) begin
                    r_regs[w_wrIdx][b*8 +: 8] <= w_wrData[b*8 +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end

    assign w_rdWordAddr = araddr >> SHIFT;
    assign w_rdErr      = (w_rdWordAddr >= ADDR_WIDTH'(NUM_REGS));
    assign w_rdIdx      = w_rdWordAddr[IDX_W-1:0];
    assign w_arHs       = arvalid && arready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdState <= R_IDLE;
        end else begin
            r_rdState <= w_rdNext;
        end
    end

    always_comb begin
        w_rdNext = r_rdState;
        case (r_rdState)
            R_IDLE: begin
                if (w_arHs) begin
                    w_rdNext = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    w_rdNext = R_IDLE;
                end
            end
            default: w_rdNext = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_rdState == R_IDLE) && !rst;
        rvalid  = (r_rdState == R_DATA);
    end

    // Sampling r_regs here yields the pre-write value when a commit lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else if (w_arHs) begin
            r_rdata <= w_rdErr ? '0 : r_regs[w_rdIdx];
            r_rresp <= w_rdErr ? SLVERR : OKAY;
        end
    end

    assign rdata = r_rdata;
    assign rresp = r_rresp;

`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wrPulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wrPulse[i] <= w_commit && !w_wrErr && (w_wrIdx == IDX_W'(i));
            end
        end
    end

    assign wr_pulse_o = r_wrPulse;
`endif

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Self-checking bench for axi4_lite_regbank (32-bit data, 16 registers): vector table
// with response scoreboards plus ordering, backpressure/collision and mid-write reset sequences.
`timescale 1ns/1ps
module tb_axi4_lite_regbank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic           clk;
    logic           rst;
    logic [AW-1:0]  awaddr;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;
    logic [NR*DW-1:0] regs_o;
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
    logic [NR-1:0]  wr_pulse_o;
`endif

    axi4_lite_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .regs_o  (regs_o)
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
        ,
        .wr_pulse_o (wr_pulse_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  expResp;
        logic [31:0] expRdata;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] modelRegs [NR];
    logic [1:0]  expB [$];
    logic [33:0] expR [$];
    int          nChecks = 0;
    int          nFails  = 0;

    task automatic checkOutput(input string name, input logic [NR*DW-1:0] actual,
                               input logic [NR*DW-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] flatModel();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) begin
            f[i*DW +: DW] = modelRegs[i];
        end
        return f;
    endfunction

    task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) modelRegs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // Called right after the final AW/W handshake edge; bready must be 1.
    task automatic finishWrite(input int idx, input logic [1:0] expResp);
        logic [1:0]    e;
        logic [NR-1:0] expPulse;
        checkOutput("b_not_early", bvalid, 0);
        tick();
        checkOutput("bvalid_rise", bvalid, 1);
        checkOutput("sb_b_size", expB.size(), 1);
        if (expB.size() > 0) begin
            e = expB.pop_front();
            checkOutput("bresp", bresp, e);
        end
        checkOutput("regs_after_commit", regs_o, flatModel());
        expPulse = '0;
        if (expResp == 2'b00 && idx < NR) expPulse[idx] = 1'b1;
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
        checkOutput("wr_pulse", wr_pulse_o, expPulse);
`endif
        tick();
        checkOutput("bvalid_drop", bvalid, 0);
        checkOutput("awready_back", awready, 1);
        checkOutput("wready_back", wready, 1);
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
        checkOutput("wr_pulse_clear", wr_pulse_o, 0);
`endif
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] expResp);
        bit awDone = 0;
        bit wDone  = 0;
        bit awH;
        bit wH;
        int cnt = 0;
        int idx;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(awDone && wDone) && cnt < 20) begin
            awH = awvalid && awready;
            wH  = wvalid && wready;
            tick();
            if (awH) begin awDone = 1; awvalid = 1'b0; end
            if (wH)  begin wDone = 1;  wvalid  = 1'b0; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("aw_w_handshake", awDone && wDone, 1);
        idx = int'(addr >> 2);
        expB.push_back(expResp);
        if (expResp == 2'b00) modelWrite(idx, data, strb);
        finishWrite(idx, expResp);
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [1:0] expResp,
                          input logic [31:0] expData);
        bit arDone = 0;
        bit arH;
        int cnt = 0;
        logic [33:0] e;
        araddr = addr; arvalid = 1'b1;
        while (!arDone && cnt < 20) begin
            arH = arvalid && arready;
            tick();
            if (arH) begin arDone = 1; arvalid = 1'b0; end
            cnt++;
        end
        arvalid = 1'b0;
        checkOutput("ar_handshake", arDone, 1);
        expR.push_back({expResp, expData});
        checkOutput("rvalid_latency", rvalid, 1);
        checkOutput("sb_r_size", expR.size(), 1);
        if (expR.size() > 0) begin
            e = expR.pop_front();
            checkOutput("rresp", rresp, e[33:32]);
            checkOutput("rdata", rdata, e[31:0]);
        end
        tick();
        checkOutput("rvalid_drop", rvalid, 0);
        checkOutput("arready_back", arready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) doWrite(v.addr, v.data, v.strb, v.expResp);
        else           doRead(v.addr, v.expResp, v.expRdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  eb;
        logic [33:0] er;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'h0, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hC, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 2'b00, 32'hCAFE_0000};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < NR; i++) modelRegs[i] = '0;

        $display("[TB] reset checks");
        repeat (3) tick();
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_bresp", bresp, 0);
        checkOutput("rst_rresp", rresp, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_regs", regs_o, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_awready", awready, 1);
        checkOutput("post_rst_wready", wready, 1);
        checkOutput("post_rst_arready", arready, 1);
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        $display("[TB] decoupled ordering: W three cycles before AW");
        wdata = 32'h5A5A_0001; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checkOutput("dec_wready_low", wready, 0);
        checkOutput("dec_awready_high", awready, 1);
        repeat (2) begin
            tick();
            checkOutput("dec_no_bvalid", bvalid, 0);
            checkOutput("dec_wready_held", wready, 0);
        end
        awaddr = 32'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checkOutput("dec_not_yet_written", regs_o, flatModel());
        expB.push_back(2'b00);
        modelWrite(5, 32'h5A5A_0001, 4'hF);
        finishWrite(5, 2'b00);

        $display("[TB] backpressure with same-register collision");
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h8; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        expB.push_back(2'b00);
        araddr = 32'h8; arvalid = 1'b1;
        checkOutput("col_arready", arready, 1);
        tick();
        arvalid = 1'b0;
        expR.push_back({2'b00, 32'hDE22_BE44});
        modelWrite(2, 32'h0BAD_F00D, 4'hF);
        checkOutput("col_bvalid", bvalid, 1);
        checkOutput("col_rvalid", rvalid, 1);
        if (expB.size() > 0) begin
            eb = expB.pop_front();
            checkOutput("col_bresp", bresp, eb);
        end
        if (expR.size() > 0) begin
            er = expR.pop_front();
            checkOutput("col_rresp", rresp, er[33:32]);
            checkOutput("col_rdata_prewrite", rdata, er[31:0]);
        end
        checkOutput("col_regs", regs_o, flatModel());
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_bvalid_hold", bvalid, 1);
            checkOutput("bp_rvalid_hold", rvalid, 1);
            checkOutput("bp_bresp_hold", bresp, 2'b00);
            checkOutput("bp_rdata_hold", rdata, 32'hDE22_BE44);
            checkOutput("bp_awready_low", awready, 0);
            checkOutput("bp_arready_low", arready, 0);
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        checkOutput("bp_bvalid_drop", bvalid, 0);
        checkOutput("bp_rvalid_drop", rvalid, 0);
        doRead(32'h8, 2'b00, 32'h0BAD_F00D);

        $display("[TB] reset in the middle of a write");
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checkOutput("rmw_aw_captured", awready, 0);
        rst = 1'b1;
        #1;
        checkOutput("rmw_awready_in_rst", awready, 0);
        checkOutput("rmw_arready_in_rst", arready, 0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) modelRegs[i] = '0;
        checkOutput("rmw_awready_back", awready, 1);
        checkOutput("rmw_wready_back", wready, 1);
        checkOutput("rmw_arready_back", arready, 1);
        checkOutput("rmw_regs_cleared", regs_o, 0);
        wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("rmw_no_bvalid", bvalid, 0);
            checkOutput("rmw_awready_wants_aw", awready, 1);
            checkOutput("rmw_reg_zero", regs_o, 0);
`ifdef AXI4_LITE_REGBANK_WR_PULSE_EN
            checkOutput("rmw_no_pulse", wr_pulse_o, 0);
`endif
        end
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        expB.push_back(2'b00);
        modelWrite(6, 32'h7777_8888, 4'hF);
        finishWrite(6, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
